serdesphy_rx_deframer: RTL and testbench

- Receive-side counterpart of the PHY serializer/framer.
- Takes the recovered serial bitstream, one bit per strobe, MSB first.
- Hunts for the sync byte, confirms frame alignment over several frames, then deserializes payload bytes into a parallel byte stream with a valid pulse.
- Sits between the RX bit-recovery front end and the tt_um top-level pin mux, where it drives status and data outputs.

---
 rtl/serdesphy_pkg.sv | 20 ++
 rtl/serdesphy_rx_shifter.sv | 45 ++++
 rtl/serdesphy_rx_deframer.sv | 158 +++++++++++++++
 tb/tb_serdesphy_rx_deframer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serdesphy_pkg.sv
// Shared definitions for the PHY serializer/framer and the receive deframer.
package serdesphy_pkg;

    // Frame alignment states.
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } deframer_state_e;

    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;

    // Bit position inside a byte (0..7).
    localparam int BIT_CNT_W   = 3;
    // Byte position inside a frame (0 = sync, 1..15 = payload).
    localparam int BYTE_IDX_W  = 4;
    // Consecutive good / missing sync byte tallies (1..7).
    localparam int FRAME_CNT_W = 3;

endpackage

// File: rtl/serdesphy_rx_shifter.sv
// Serial-to-parallel shifter: 8-bit MSB-first shift register plus in-byte
// bit counter. byte_done_o flags the strobe that brings the counter 7 -> 0.
// While cnt_clr_i is high (hunting) the counter is pinned to 0 so the next
// byte boundary is measured from the strobe that found the sync word.
module serdesphy_rx_shifter
    import serdesphy_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       shift_en_i,
    input  logic       bit_i,
    input  logic       cnt_clr_i,
    output logic [7:0] next_byte_o,
    output logic       byte_done_o
);

    logic [7:0]           sr_q, sr_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    // Window as it will look after the current strobe is shifted in.
    assign next_byte_o = {sr_q[6:0], bit_i};
    assign byte_done_o = shift_en_i & ~cnt_clr_i & (bit_cnt_q == '1);

    // Shift and count only on accepted strobes; otherwise hold everything.
    always_comb begin
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        if (shift_en_i) begin
            sr_d      = next_byte_o;
            bit_cnt_d = cnt_clr_i ? '0 : bit_cnt_q + BIT_CNT_W'(1);
        end
    end

    // Shift register and bit counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
        end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/serdesphy_rx_deframer.sv
// Receive deframer: hunts for the sync byte in the recovered bitstream,
// confirms alignment over several frames, then emits payload bytes.
// In LOCKED a missing sync byte is tolerated (flywheel) until a run of
// misses drops the link back to HUNT.
module serdesphy_rx_deframer
    import serdesphy_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD     = SYNC_WORD_DEFAULT,
    parameter int          PAYLOAD_BYTES = 4,
    parameter int          LOCK_COUNT    = 2,
    parameter int          UNLOCK_COUNT  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       rx_bit,
    input  logic       rx_bit_en,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       locked,
    output logic       sync_err,
    output logic       frame_start
);

    deframer_state_e        state_q, state_d;
    logic [BYTE_IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic [FRAME_CNT_W-1:0] good_cnt_q, good_cnt_d;
    logic [FRAME_CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [7:0]             data_q, data_d;
    logic                   data_valid_q, data_valid_d;
    logic                   locked_q, locked_d;
    logic                   sync_err_q, sync_err_d;
    logic                   frame_start_q, frame_start_d;

    logic                   accept;
    logic                   hunting;
    logic [7:0]             next_byte;
    logic                   byte_done;
    logic                   sync_match;
    logic                   last_idx;
    logic [FRAME_CNT_W-1:0] good_inc;
    logic [FRAME_CNT_W-1:0] miss_inc;

    assign accept     = rx_bit_en & ena;
    assign hunting    = (state_q == HUNT);
    assign sync_match = (next_byte == SYNC_WORD);
    assign last_idx   = (byte_idx_q == BYTE_IDX_W'(PAYLOAD_BYTES));
    assign good_inc   = good_cnt_q + FRAME_CNT_W'(1);
    assign miss_inc   = miss_cnt_q + FRAME_CNT_W'(1);

    serdesphy_rx_shifter u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en_i (accept),
        .bit_i      (rx_bit),
        .cnt_clr_i  (hunting),
        .next_byte_o(next_byte),
        .byte_done_o(byte_done)
    );

    // Alignment FSM, frame position tracking and output pulse generation.
    always_comb begin
        state_d       = state_q;
        byte_idx_d    = byte_idx_q;
        good_cnt_d    = good_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        data_d        = data_q;
        data_valid_d  = 1'b0;
        sync_err_d    = 1'b0;
        frame_start_d = 1'b0;

        // byte_done never fires while hunting, so this only advances an aligned frame.
        if (byte_done) begin
            byte_idx_d = last_idx ? '0 : byte_idx_q + BYTE_IDX_W'(1);
        end

        case (state_q)
            HUNT: begin
                // Sliding-window search; the matching strobe defines byte 0.
                if (accept && sync_match) begin
                    byte_idx_d = BYTE_IDX_W'(1);
                    good_cnt_d = FRAME_CNT_W'(1);
                    miss_cnt_d = '0;
                    state_d    = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
                end
            end
            VERIFY: begin
                if (byte_done && (byte_idx_q == '0)) begin
                    if (sync_match) begin
                        good_cnt_d = good_inc;
                        if (good_inc == FRAME_CNT_W'(LOCK_COUNT)) begin
                            state_d    = LOCKED;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                    end
                end
            end
            LOCKED: begin
                if (byte_done) begin
                    if (byte_idx_q != '0) begin
                        // Payload is never compared against the sync word.
                        data_d       = next_byte;
                        data_valid_d = 1'b1;
                    end else if (sync_match) begin
                        miss_cnt_d    = '0;
                        frame_start_d = 1'b1;
                    end else begin
                        sync_err_d = 1'b1;
                        miss_cnt_d = miss_inc;
                        if (miss_inc == FRAME_CNT_W'(UNLOCK_COUNT)) begin
                            state_d = HUNT;
                        end
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase

        locked_d = (state_d == LOCKED);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            byte_idx_q    <= '0;
            good_cnt_q    <= '0;
            miss_cnt_q    <= '0;
            data_q        <= '0;
            data_valid_q  <= 1'b0;
            locked_q      <= 1'b0;
            sync_err_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_idx_q    <= byte_idx_d;
            good_cnt_q    <= good_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            locked_q      <= locked_d;
            sync_err_q    <= sync_err_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign data_out    = data_q;
    assign data_valid  = data_valid_q;
    assign locked      = locked_q;
    assign sync_err    = sync_err_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_serdesphy_rx_deframer.sv
// Bench for serdesphy_rx_deframer: directed frame scenarios plus a random
// stream, every cycle checked against a bit-position reference model.
`timescale 1ns/1ps
module tb_serdesphy_rx_deframer;

    localparam logic [7:0] SYNC    = 8'hA5;
    localparam int         PB      = 4;
    localparam int         LOCKN   = 2;
    localparam int         UNLOCKN = 3;
    localparam int         FB      = 8 * (PB + 1);

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       ena       = 1'b0;
    logic       rx_bit    = 1'b0;
    logic       rx_bit_en = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       locked;
    logic       sync_err;
    logic       frame_start;

    serdesphy_rx_deframer #(
        .SYNC_WORD    (SYNC),
        .PAYLOAD_BYTES(PB),
        .LOCK_COUNT   (LOCKN),
        .UNLOCK_COUNT (UNLOCKN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .rx_bit     (rx_bit),
        .rx_bit_en  (rx_bit_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .locked     (locked),
        .sync_err   (sync_err),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: mode 0 hunt, 1 verify, 2 locked; pos = bits since the
    // end of the last sync byte, modulo the frame length in bits.
    int         m_mode, m_pos, m_good, m_miss;
    logic [7:0] m_win, m_data;
    logic       m_dv, m_se, m_fs;

    // Observed tallies for scenario-level checks.
    int         dv_cnt, se_cnt, fs_cnt;
    int         got_q[$];
    bit         lock_seen, lock_drop;
    logic [7:0] pay [PB];

    task automatic chk(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: got %0h, required %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_good = 0; m_miss = 0;
        m_win = 8'h00; m_data = 8'h00;
        m_dv = 1'b0; m_se = 1'b0; m_fs = 1'b0;
    endtask

    task automatic model_step();
        m_dv = 1'b0; m_se = 1'b0; m_fs = 1'b0;
        if (rx_bit_en && ena) begin
            m_win = {m_win[6:0], rx_bit};
            if (m_mode == 0) begin
                if (m_win == SYNC) begin
                    m_pos = 0; m_good = 1; m_miss = 0;
                    m_mode = (LOCKN == 1) ? 2 : 1;
                end
            end else begin
                m_pos = (m_pos + 1) % FB;
                if (m_pos == 0) begin
                    if (m_mode == 1) begin
                        if (m_win == SYNC) begin
                            m_good++;
                            if (m_good == LOCKN) begin m_mode = 2; m_miss = 0; end
                        end else begin
                            m_se = 1'b1; m_mode = 0;
                        end
                    end else begin
                        if (m_win == SYNC) begin
                            m_fs = 1'b1; m_miss = 0;
                        end else begin
                            m_se = 1'b1; m_miss++;
                            if (m_miss == UNLOCKN) m_mode = 0;
                        end
                    end
                end else if ((m_pos % 8 == 0) && (m_mode == 2)) begin
                    m_dv = 1'b1; m_data = m_win;
                end
            end
        end
    endtask

    task automatic clear_tallies();
        dv_cnt = 0; se_cnt = 0; fs_cnt = 0;
        got_q.delete();
        lock_seen = 1'b0; lock_drop = 1'b0;
    endtask

    // One clock: drive, advance model on the edge, compare all outputs.
    task automatic cyc(input logic en, input logic b, input logic e);
        rx_bit_en = en; rx_bit = b; ena = e;
        @(posedge clk);
        model_step();
        #1;
        chk("data_out",    int'(data_out),    int'(m_data));
        chk("data_valid",  int'(data_valid),  int'(m_dv));
        chk("sync_err",    int'(sync_err),    int'(m_se));
        chk("frame_start", int'(frame_start), int'(m_fs));
        chk("locked",      int'(locked),      (m_mode == 2) ? 1 : 0);
        if (data_valid) begin dv_cnt++; got_q.push_back(int'(data_out)); end
        if (sync_err) se_cnt++;
        if (frame_start) fs_cnt++;
        if (locked) lock_seen = 1'b1;
        if (lock_seen && !locked) lock_drop = 1'b1;
    endtask

    // mode 0: full rate, 1: one strobe in three, 2: random gaps with ena=0 noise.
    task automatic send_bits(input logic [7:0] v, input int hi, input int lo, input int mode);
        int idle;
        for (int i = hi; i >= lo; i--) begin
            if (mode == 2) begin
                idle = int'($urandom_range(0, 2));
                for (int k = 0; k < idle; k++) begin
                    if ($urandom_range(0, 1) == 1)
                        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                    else
                        cyc(1'b0, 1'($urandom_range(0, 1)), 1'b1);
                end
            end
            cyc(1'b1, v[i], 1'b1);
            if (mode == 1) begin
                cyc(1'b0, 1'b0, 1'b1);
                cyc(1'b0, 1'b0, 1'b1);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input int mode);
        send_bits(v, 7, 0, mode);
    endtask

    task automatic send_frame(input logic [7:0] s, input int mode);
        send_byte(s, mode);
        for (int i = 0; i < PB; i++) send_byte(pay[i], mode);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b1);
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_rst_data_out"},    int'(data_out),    0);
        chk({tag, "_rst_data_valid"},  int'(data_valid),  0);
        chk({tag, "_rst_locked"},      int'(locked),      0);
        chk({tag, "_rst_sync_err"},    int'(sync_err),    0);
        chk({tag, "_rst_frame_start"}, int'(frame_start), 0);
        model_reset();
        rx_bit_en = 1'b0; rx_bit = 1'b0; ena = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_rst_hold_locked"}, int'(locked), 0);
        rst_n = 1'b1;
        clear_tallies();
    endtask

    task automatic set_pay_default();
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    endtask

    // Three frames; lock after the 2nd sync, four bytes and one frame_start in the 3rd.
    task automatic lock_and_check(input string tag, input int mode, input bit pause);
        set_pay_default();
        send_frame(SYNC, mode);
        chk({tag, "_locked_after_f1"}, int'(locked), 0);
        send_byte(SYNC, mode);
        chk({tag, "_locked_at_sync2"}, int'(locked), 1);
        for (int i = 0; i < PB; i++) send_byte(pay[i], mode);
        clear_tallies();
        send_byte(SYNC, mode);
        send_byte(pay[0], mode);
        if (pause) begin
            send_bits(pay[1], 7, 4, mode);
            for (int k = 0; k < 10; k++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            send_bits(pay[1], 3, 0, mode);
        end else begin
            send_byte(pay[1], mode);
        end
        send_byte(pay[2], mode);
        send_byte(pay[3], mode);
        chk({tag, "_f3_dv_cnt"}, dv_cnt, 4);
        chk({tag, "_f3_fs_cnt"}, fs_cnt, 1);
        chk({tag, "_f3_se_cnt"}, se_cnt, 0);
        for (int i = 0; i < PB; i++)
            chk({tag, "_f3_byte"}, (got_q.size() > i) ? got_q[i] : -1, int'(pay[i]));
    endtask

    initial begin
        logic [4:0] pre;
        logic [7:0] s;
        model_reset();
        clear_tallies();

        // Clean lock at full rate.
        do_reset("clean");
        idle_bits(16);
        lock_and_check("clean", 0, 1'b0);

        // Random bit offset ahead of the first frame; 10100 would
        // complete a sync word early with the head of A5, so avoid it.
        do_reset("offset");
        idle_bits(16);
        pre = 5'($urandom);
        if (pre == 5'b10100) pre = 5'b01011;
        for (int i = 4; i >= 0; i--) cyc(1'b1, pre[i], 1'b1);
        lock_and_check("offset", 0, 1'b0);

        // Lone sync byte, then a non-sync byte at the next frame position.
        do_reset("false");
        idle_bits(12);
        set_pay_default();
        send_frame(SYNC, 0);
        send_byte(8'h00, 0);
        chk("false_sync_err_pulse", int'(sync_err), 1);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("false_se_cnt", se_cnt, 1);
        chk("false_lock_seen", int'(lock_seen), 0);
        chk("false_dv_cnt", dv_cnt, 0);

        // Flywheel: two misses keep lock, a good frame resets, three misses unlock.
        do_reset("fly");
        idle_bits(16);
        for (int i = 0; i < PB; i++) pay[i] = 8'($urandom);
        pay[2] = SYNC;
        send_frame(SYNC, 0);
        send_frame(SYNC, 0);
        clear_tallies();
        send_frame(8'h00, 0);
        send_frame(8'h00, 0);
        chk("fly_se_cnt_2", se_cnt, 2);
        chk("fly_locked_kept", int'(locked), 1);
        chk("fly_no_drop", int'(lock_drop), 0);
        send_frame(SYNC, 0);
        chk("fly_fs_cnt", fs_cnt, 1);
        chk("fly_dv_cnt", dv_cnt, 3 * PB);
        send_frame(8'h00, 0);
        send_frame(8'h00, 0);
        chk("fly_locked_2miss", int'(locked), 1);
        send_byte(8'h00, 0);
        chk("fly_unlocked_3miss", int'(locked), 0);
        chk("fly_se_cnt_5", se_cnt, 5);

        // Strobe gaps and an ena=0 pause mid-byte.
        do_reset("gap");
        idle_bits(16);
        lock_and_check("gap", 1, 1'b1);

        // Asynchronous reset after the 4th bit of payload byte 2.
        do_reset("mid");
        idle_bits(16);
        set_pay_default();
        send_frame(SYNC, 0);
        send_frame(SYNC, 0);
        send_byte(SYNC, 0);
        send_byte(pay[0], 0);
        send_bits(pay[1], 7, 4, 0);
        chk("mid_locked_before", int'(locked), 1);
        do_reset("mid");
        idle_bits(8);
        send_frame(SYNC, 0);
        chk("mid_relock_f1", int'(locked), 0);
        send_byte(SYNC, 0);
        chk("mid_relock_sync2", int'(locked), 1);

        // Random stream: random payloads, occasional bad sync bytes, random strobing.
        do_reset("rand");
        idle_bits(8);
        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < PB; i++) pay[i] = 8'($urandom);
            s = ($urandom_range(0, 4) == 0) ? 8'($urandom) : SYNC;
            send_frame(s, 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
